// File: rtl/fft8_stream_pipe_if.sv
// Stream bus for fft8_stream_pipe: one complex 8-sample frame in, one 8-bin
// spectrum out, each with valid/ready. DW must match the attached block.
// With FFT8_INVERSE_EN defined, a per-frame inv bit travels with the input.
interface fft8_stream_pipe_if #(
  parameter int DW = 8
);
  localparam int OW = DW + 4;

  logic            in_valid;
  logic            in_ready;
  logic [8*DW-1:0] in_re;
  logic [8*DW-1:0] in_im;
`ifdef FFT8_INVERSE_EN
  logic            inv;
`endif
  logic            out_valid;
  logic            out_ready;
  logic [8*OW-1:0] out_re;
  logic [8*OW-1:0] out_im;

`ifdef FFT8_INVERSE_EN
  // master: the FFT block itself
  modport master (
    input  in_valid, in_re, in_im, inv, out_ready,
    output in_ready, out_valid, out_re, out_im
  );
  // slave: the surrounding source/sink
  modport slave (
    output in_valid, in_re, in_im, inv, out_ready,
    input  in_ready, out_valid, out_re, out_im
  );
`else
  // master: the FFT block itself
  modport master (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im
  );
  // slave: the surrounding source/sink
  modport slave (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im
  );
`endif
endinterface

// File: rtl/fft8_stream_pipe.sv
// fft8_stream_pipe: 8-point radix-2 DIT FFT on complex frames, one frame per
// cycle, 4 advancing cycles of latency, whole-pipeline stall on back-pressure.
// Stages: S1 butterflies (DW+1) -> S2 butterflies with W4 swap (DW+2) ->
// ROT twiddle stage (DW+3) -> S3 butterflies (DW+4). Outputs in natural order.
// Optional macro FFT8_INVERSE_EN: per-frame inv bit selects conjugate
// twiddles, giving the unscaled IDFT for that frame.
module fft8_stream_pipe #(
  parameter int DW = 8,
  parameter int TW = 8
) (
  input  logic              clk,
  input  logic              reset,
  fft8_stream_pipe_if.master bus
);
  localparam int W1 = DW + 1;
  localparam int W2 = DW + 2;
  localparam int W3 = DW + 3;
  localparam int OW = DW + 4;
  localparam int PW = W3 + TW;
  localparam int C_INT = $rtoi(0.70710678 * real'(1 << (TW - 1)) + 0.5);
  localparam logic signed [PW-1:0] C_PW   = PW'(C_INT);
  localparam logic signed [PW-1:0] RND_PW = PW'(1 << (TW - 2));

  // Round-half-up then drop the TW-1 fraction bits of a twiddle product.
  function automatic logic signed [W3-1:0] rnd(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] t;
    t = (p + RND_PW) >>> (TW - 1);
    return t[W3-1:0];
  endfunction

  logic w_en;
  logic w_inv1;
  logic w_inv2;
  logic r_v1, r_v2, r_v3, r_v4;

  logic signed [DW-1:0] w_x_re   [8];
  logic signed [DW-1:0] w_x_im   [8];
  logic signed [W1-1:0] w_s1_re  [8];
  logic signed [W1-1:0] w_s1_im  [8];
  logic signed [W1-1:0] r_s1_re  [8];
  logic signed [W1-1:0] r_s1_im  [8];
  logic signed [W2-1:0] w_j_re   [2];
  logic signed [W2-1:0] w_j_im   [2];
  logic signed [W2-1:0] w_s2_re  [8];
  logic signed [W2-1:0] w_s2_im  [8];
  logic signed [W2-1:0] r_s2_re  [8];
  logic signed [W2-1:0] r_s2_im  [8];
  logic signed [W3-1:0] w_sum5, w_dif5, w_sum7, w_dif7;
  logic signed [PW-1:0] w_ps5, w_pd5, w_ps7, w_pd7;
  logic signed [W3-1:0] w_rot_re [8];
  logic signed [W3-1:0] w_rot_im [8];
  logic signed [W3-1:0] r_rot_re [8];
  logic signed [W3-1:0] r_rot_im [8];
  logic signed [OW-1:0] w_s3_re  [8];
  logic signed [OW-1:0] w_s3_im  [8];
  logic signed [OW-1:0] r_s3_re  [8];
  logic signed [OW-1:0] r_s3_im  [8];
  logic [8*OW-1:0]      w_out_re;
  logic [8*OW-1:0]      w_out_im;

  // Whole pipeline advances when the output slot is empty or being drained.
  assign w_en          = bus.out_ready | ~r_v4;
  assign bus.in_ready  = w_en;
  assign bus.out_valid = r_v4;

  // Unpack input samples.
  for (genvar gi = 0; gi < 8; gi++) begin : g_in
    assign w_x_re[gi] = bus.in_re[gi*DW +: DW];
    assign w_x_im[gi] = bus.in_im[gi*DW +: DW];
  end

  // S1: bit-reversed pairs (0,4), (2,6), (1,5), (3,7); sum in even slot, difference in odd.
  for (genvar gi = 0; gi < 4; gi++) begin : g_s1
    localparam int LO = (gi % 2) * 2 + (gi / 2);
    assign w_s1_re[2*gi]   = W1'(w_x_re[LO]) + W1'(w_x_re[LO+4]);
    assign w_s1_im[2*gi]   = W1'(w_x_im[LO]) + W1'(w_x_im[LO+4]);
    assign w_s1_re[2*gi+1] = W1'(w_x_re[LO]) - W1'(w_x_re[LO+4]);
    assign w_s1_im[2*gi+1] = W1'(w_x_im[LO]) - W1'(w_x_im[LO+4]);
  end

  // S2: two 4-point stages (even half 0..3, odd half 4..7); the W4^1 term is an exact -j (or +j) swap.
  always_comb begin
    for (int h = 0; h < 2; h++) begin
      if (w_inv1) begin
        w_j_re[h] = -W2'(r_s1_im[4*h+3]);
        w_j_im[h] =  W2'(r_s1_re[4*h+3]);
      end else begin
        w_j_re[h] =  W2'(r_s1_im[4*h+3]);
        w_j_im[h] = -W2'(r_s1_re[4*h+3]);
      end
      w_s2_re[4*h]   = W2'(r_s1_re[4*h])   + W2'(r_s1_re[4*h+2]);
      w_s2_im[4*h]   = W2'(r_s1_im[4*h])   + W2'(r_s1_im[4*h+2]);
      w_s2_re[4*h+2] = W2'(r_s1_re[4*h])   - W2'(r_s1_re[4*h+2]);
      w_s2_im[4*h+2] = W2'(r_s1_im[4*h])   - W2'(r_s1_im[4*h+2]);
      w_s2_re[4*h+1] = W2'(r_s1_re[4*h+1]) + w_j_re[h];
      w_s2_im[4*h+1] = W2'(r_s1_im[4*h+1]) + w_j_im[h];
      w_s2_re[4*h+3] = W2'(r_s1_re[4*h+1]) - w_j_re[h];
      w_s2_im[4*h+3] = W2'(r_s1_im[4*h+1]) - w_j_im[h];
    end
  end

  // ROT: odd-half bins get W8^k; W^0 passes, W^2 is a swap, W^1/W^3 use C with rounding.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      w_rot_re[i] = W3'(r_s2_re[i]);
      w_rot_im[i] = W3'(r_s2_im[i]);
    end
    if (w_inv2) begin
      w_rot_re[6] = -W3'(r_s2_im[6]);
      w_rot_im[6] =  W3'(r_s2_re[6]);
    end else begin
      w_rot_re[6] =  W3'(r_s2_im[6]);
      w_rot_im[6] = -W3'(r_s2_re[6]);
    end
    w_sum5 = W3'(r_s2_re[5]) + W3'(r_s2_im[5]);
    w_dif5 = W3'(r_s2_im[5]) - W3'(r_s2_re[5]);
    w_sum7 = W3'(r_s2_re[7]) + W3'(r_s2_im[7]);
    w_dif7 = W3'(r_s2_im[7]) - W3'(r_s2_re[7]);
    w_ps5  = PW'(w_sum5) * C_PW;
    w_pd5  = PW'(w_dif5) * C_PW;
    w_ps7  = PW'(w_sum7) * C_PW;
    w_pd7  = PW'(w_dif7) * C_PW;
    if (w_inv2) begin
      w_rot_re[5] = rnd(-w_pd5);
      w_rot_im[5] = rnd(w_ps5);
      w_rot_re[7] = rnd(-w_ps7);
      w_rot_im[7] = rnd(-w_pd7);
    end else begin
      w_rot_re[5] = rnd(w_ps5);
      w_rot_im[5] = rnd(w_pd5);
      w_rot_re[7] = rnd(w_pd7);
      w_rot_im[7] = rnd(-w_ps7);
    end
  end

  // S3: final butterflies combine even-half bins with rotated odd-half bins.
  for (genvar gi = 0; gi < 4; gi++) begin : g_s3
    assign w_s3_re[gi]   = OW'(r_rot_re[gi]) + OW'(r_rot_re[gi+4]);
    assign w_s3_im[gi]   = OW'(r_rot_im[gi]) + OW'(r_rot_im[gi+4]);
    assign w_s3_re[gi+4] = OW'(r_rot_re[gi]) - OW'(r_rot_re[gi+4]);
    assign w_s3_im[gi+4] = OW'(r_rot_im[gi]) - OW'(r_rot_im[gi+4]);
  end

  // Pipeline registers and valid bits: shift together on w_en, hold otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
      r_v4 <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_s1_re[i]  <= '0;
        r_s1_im[i]  <= '0;
        r_s2_re[i]  <= '0;
        r_s2_im[i]  <= '0;
        r_rot_re[i] <= '0;
        r_rot_im[i] <= '0;
        r_s3_re[i]  <= '0;
        r_s3_im[i]  <= '0;
      end
    end else if (w_en) begin
      r_v1 <= bus.in_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      r_v4 <= r_v3;
      for (int i = 0; i < 8; i++) begin
        r_s1_re[i]  <= w_s1_re[i];
        r_s1_im[i]  <= w_s1_im[i];
        r_s2_re[i]  <= w_s2_re[i];
        r_s2_im[i]  <= w_s2_im[i];
        r_rot_re[i] <= w_rot_re[i];
        r_rot_im[i] <= w_rot_im[i];
        r_s3_re[i]  <= w_s3_re[i];
        r_s3_im[i]  <= w_s3_im[i];
      end
    end
  end

`ifdef FFT8_INVERSE_EN
  logic r_inv1, r_inv2;

  // Per-frame direction bit rides alongside the data as far as the ROT stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inv1 <= 1'b0;
      r_inv2 <= 1'b0;
    end else if (w_en) begin
      r_inv1 <= bus.inv;
      r_inv2 <= r_inv1;
    end
  end

  assign w_inv1 = r_inv1;
  assign w_inv2 = r_inv2;
`else
  assign w_inv1 = 1'b0;
  assign w_inv2 = 1'b0;
`endif

  // Pack the output bins onto the bus.
  always_comb begin
    w_out_re = '0;
    w_out_im = '0;
    for (int k = 0; k < 8; k++) begin
      w_out_re[k*OW +: OW] = r_s3_re[k];
      w_out_im[k*OW +: OW] = r_s3_im[k];
    end
  end

  assign bus.out_re = w_out_re;
  assign bus.out_im = w_out_im;

endmodule

// File: doc/fft8_stream_pipe.md
Name: fft8_stream_pipe

Overview:
- Parametrised successor to the team's fixed 8-bit, real-input, 8-point pipelined butterfly FFT.
- Accepts one complex 8-sample frame per cycle and produces the 8-point radix-2 DIT FFT in natural order after a fixed 4-cycle latency.
- Width-generic signed data, parametrised twiddle precision, valid/ready flow control with full-pipeline stall.
- Sits between the sample framer and the spectrum post-processing block.

Parameters:
- DW, 8, signed input component width (re and im each).
- TW, 8, signed twiddle width. C = round(0.70710678 * 2^(TW-1)); TW=8 gives C=91.
- OW (localparam), DW+4, signed output component width. Full growth, so no overflow is possible.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  input frame valid
- in_ready  out  1  block can accept a frame this cycle
- in_re  in  8*DW  x[n] real parts, sample n at bits [n*DW +: DW]
- in_im  in  8*DW  x[n] imaginary parts, same packing
- out_valid  out  1  output frame valid
- out_ready  in  1  downstream accepts the frame
- out_re  out  8*OW  X[k] real parts, bin k at [k*OW +: OW]
- out_im  out  8*OW  X[k] imaginary parts

Behaviour:
- Reset (reset=0, async): all pipeline data registers, the valid bits v1..v4, out_valid, out_re and out_im go to 0. in_ready reads 1 while reset is held and after release.
- Pipeline: S1 butterflies (DW+1), S2 butterflies with the W4 -j swap (DW+2), ROT twiddle register (DW+3), S3 butterflies (DW+4).
- Latency: exactly 4 advancing cycles, accepted frame to out_valid.
- Input bit-reversal is done by wiring. S1 pairs are (0,4), (2,6), (1,5), (3,7).
- Multiply by -j is exact: (a+jb) becomes (b - ja).
- W^1 rotation of (a+jb) = ((a+b)*C, (b-a)*C) >>> (TW-1). W^3 rotation = ((b-a)*C, -(a+b)*C) >>> (TW-1).
- Rounding before each shift: add 2^(TW-2), then arithmetic shift right (round-half-up; -45.5 becomes -45).
- W^0 and W^2 paths pass through the ROT stage unmultiplied; W^2 is applied as the -j swap.
- All arithmetic is signed and sign-extended at every stage. No saturation or wrap can occur.
- Handshake: en = out_ready | ~out_valid, and in_ready = en.
  - When en=1, every stage register and valid bit shifts one place. v1 loads in_valid & in_ready.
  - When en=0, all stages hold, including data and valid bits.
  - Bubbles are not collapsed.
- out_valid/out_re/out_im stay stable while out_valid=1 and out_ready=0.
- A frame transfers on out_valid & out_ready. Simultaneous input and output transfer in the same cycle is legal and sustains 1 frame/cycle.
- in_valid=1 with in_ready=0: no capture. The source must hold its data.
- Reset asserted mid-operation: all in-flight frames are discarded and no partial frame is emitted.
- Data registers may load when the matching valid bit is 0 (don't-care), but out_re/out_im must be 0 after reset until the first valid frame.

Optional Feature:
- Macro FFT8_INVERSE_EN.
- Defined:
  - Adds input port inv (1 bit), captured with each accepted frame and carried through the pipeline alongside the valid bits.
  - When a frame's inv bit = 1, that frame uses conjugated twiddles (the -j swap becomes +j; W^1/W^3 use conjugate formulas), giving the unscaled IDFT.
  - Modes can switch frame-to-frame with no bubble.
- Undefined: no inv port; forward transform only. Datapath and latency are identical.

Test Plan:
- Impulse, DW=8: x0=100+j0, others 0, out_ready=1 -> 4 cycles later all X[k]=100+j0, out_valid=1 for exactly 1 cycle.
- Shifted impulse: x1=64, others 0 -> X0=64, X1=46-j45, X2=0-j64, X3=-45-j45, X4=-64, X5=-46+j45, X6=0+j64, X7=45+j45.
- Real frame x=(82,44,62,79,92,74,18,41) -> X0=492+j0, X4=16+j0, X2=94+j2, X6=94-j2.
- Back-pressure: stream 6 back-to-back frames, hold out_ready=0 for 3 cycles when out_valid first rises -> in_ready=0 during the hold, outputs held stable, all 6 frames emitted in order with none lost or duplicated.
- Reset mid-stream: assert reset low with 3 frames in flight -> out_valid=0 and outputs 0 immediately; after release, the first new frame appears 4 cycles after acceptance.
- FFT8_INVERSE_EN: x1=64 with inv=1 -> X1=46+j46 (rounding on +C*64), X2=0+j64, X6=0-j64. Alternate inv every frame -> each output matches its own frame's mode.
